// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single DMEM port of the MEM stage between two requesters:
//     r0 = pipeline MEM stage (load/store)
//     r1 = secondary master (loader/DMA)
//   Round-robin arbitration. r1 may hold a locked burst, capped at MAX_BURST
//   consecutive grants whenever r0 is waiting. Read data returns RD_LAT
//   cycles after the grant and is steered by a {valid,owner} tag pipeline.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   r0_req/we/addr/wdata       r0 request; held until r0_gnt
//   r0_gnt, r0_stall           r0 accepted this cycle / r0 waiting
//   r0_rvalid, r0_rdata        r0 load data return
//   r1_req/we/addr/wdata/lock  r1 request, lock asks for a burst
//   r1_gnt, r1_rvalid, r1_rdata
//   mem_en/we/addr/wdata       DMEM command (zeroed when nothing granted)
//   mem_rdata                  DMEM read data, RD_LAT cycles after a read
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8,
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_stall,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        S_ARB   = 2'd0,
        S_BURST = 2'd1,
        S_YIELD = 2'd2
    } state_t;

    state_t          state_reg;
    logic            last_reg;        // 0 = r0 granted last, 1 = r1
    logic [CW-1:0]   burst_cnt_reg;
    logic [CW-1:0]   cnt_inc;

    logic            gnt0;
    logic            gnt1;
    logic            pick0;
    logic            pick1;
    logic            arb_mode;

    assign cnt_inc = burst_cnt_reg + CW'(1);

    // Plain round-robin pick: on a tie the port that was not served last wins.
    assign pick1 = r1_req & (~r0_req | ~last_reg);
    assign pick0 = r0_req & ~pick1;

    // Grant decode. S_BURST falls back to round-robin in the same cycle the
    // burst ends, so a waiting r0 is not delayed by the state change.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        arb_mode = 1'b0;
        case (state_reg)
            S_BURST: begin
                if (r1_req && r1_lock) begin
                    // A saturated burst gives way to a waiting r0: no grant
                    // this cycle, r0 is served from S_YIELD next cycle.
                    gnt1 = (burst_cnt_reg != MAX_CNT) || !r0_req;
                end else begin
                    arb_mode = 1'b1;
                end
            end
            S_YIELD: gnt0 = r0_req;
            default: arb_mode = 1'b1;
        endcase
        if (arb_mode) begin
            gnt0 = pick0;
            gnt1 = pick1;
        end
    end

    // Arbitration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_ARB;
            last_reg      <= 1'b1;
            burst_cnt_reg <= '0;
        end else begin
            if (gnt1) begin
                last_reg <= 1'b1;
            end else if (gnt0 || state_reg == S_YIELD) begin
                last_reg <= 1'b0;
            end

            if (arb_mode) begin
                if (gnt1 && r1_lock) begin
                    state_reg     <= S_BURST;
                    burst_cnt_reg <= CW'(1);
                end else begin
                    state_reg     <= S_ARB;
                    burst_cnt_reg <= '0;
                end
            end else begin
                case (state_reg)
                    S_BURST: begin
                        if (gnt1 && burst_cnt_reg != MAX_CNT) begin
                            burst_cnt_reg <= cnt_inc;
                        end
                        // Leave as soon as the cap is reached with r0 waiting,
                        // so r0 is served right after the last burst beat.
                        if (r0_req && (!gnt1 || cnt_inc == MAX_CNT)) begin
                            state_reg <= S_YIELD;
                        end
                    end
                    default: begin
                        state_reg     <= S_ARB;
                        burst_cnt_reg <= '0;
                    end
                endcase
            end
        end
    end

    // DMEM command mux
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end else if (gnt1) begin
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end
    end

    assign mem_en   = gnt0 | gnt1;
    assign r0_gnt   = gnt0;
    assign r1_gnt   = gnt1;
    assign r0_stall = r0_req & ~gnt0;

    // Read-return tag pipeline, one stage per cycle of DMEM latency.
    logic [RD_LAT-1:0] tag_valid_reg;
    logic [RD_LAT-1:0] tag_owner_reg;
    logic [RD_LAT-1:0] tag_valid_next;
    logic [RD_LAT-1:0] tag_owner_next;

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_next[gi] = mem_en & ~mem_we;
                assign tag_owner_next[gi] = gnt1;
            end else begin : g_body
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_owner_next[gi] = tag_owner_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_reg <= '0;
            tag_owner_reg <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_owner_reg <= tag_owner_next;
        end
    end

    assign r0_rvalid = tag_valid_reg[RD_LAT-1] & ~tag_owner_reg[RD_LAT-1];
    assign r1_rvalid = tag_valid_reg[RD_LAT-1] &  tag_owner_reg[RD_LAT-1];
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Two arbiters (RD_LAT=1 and RD_LAT=3) share the same request stimulus.
//   Per-cycle vectors give the expected grants; read grants push the expected
//   {owner, data, due cycle} into a scoreboard that is popped on rvalid.
//   The DMEM model returns an address-derived pattern for every read.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r0_we, r1_req, r1_we, r1_lock;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

    logic        a_r0_gnt, a_r0_stall, a_r0_rvalid, a_r1_gnt, a_r1_rvalid;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_r0_rdata, a_r1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_r0_gnt, b_r0_stall, b_r0_rvalid, b_r1_gnt, b_r1_rvalid;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_r0_rdata, b_r1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(8), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(a_r0_gnt), .r0_stall(a_r0_stall), .r0_rvalid(a_r0_rvalid),
        .r0_rdata(a_r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(a_r1_gnt), .r1_rvalid(a_r1_rvalid),
        .r1_rdata(a_r1_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .MAX_BURST(8), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(b_r0_gnt), .r0_stall(b_r0_stall), .r0_rvalid(b_r0_rvalid),
        .r0_rdata(b_r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid),
        .r1_rdata(b_r1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    // DMEM models with 1 and 3 cycles of read latency
    logic [31:0] a_rd_pipe;
    logic [31:0] b_rd_pipe [3];
    always @(posedge clk) begin
        a_rd_pipe    <= (a_mem_en && !a_mem_we) ? pat(a_mem_addr) : 32'hDEAD_BEEF;
        b_rd_pipe[0] <= (b_mem_en && !b_mem_we) ? pat(b_mem_addr) : 32'hDEAD_BEEF;
        b_rd_pipe[1] <= b_rd_pipe[0];
        b_rd_pipe[2] <= b_rd_pipe[1];
    end
    assign a_mem_rdata = a_rd_pipe;
    assign b_mem_rdata = b_rd_pipe[2];

    typedef struct {
        logic        r0_req;
        logic        r0_we;
        logic [31:0] r0_addr;
        logic        r1_req;
        logic        r1_we;
        logic        r1_lock;
        logic [31:0] r1_addr;
        logic        g0;
        logic        g1;
    } vec_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } sb_t;

    vec_t vecs[$];
    sb_t  q1[$];
    sb_t  q3[$];
    int   tests;
    int   errors;
    int   cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input logic q0, input logic w0, input logic [31:0] a0,
                       input logic q1_, input logic w1, input logic l1, input logic [31:0] a1,
                       input logic g0, input logic g1);
        vec_t v;
        v.r0_req = q0; v.r0_we = w0; v.r0_addr = a0;
        v.r1_req = q1_; v.r1_we = w1; v.r1_lock = l1; v.r1_addr = a1;
        v.g0 = g0; v.g1 = g1;
        vecs.push_back(v);
    endtask

    // Compare one DUT's read-return port against the head of its scoreboard.
    task automatic mon(input bit sel3, input logic rv0, input logic rv1,
                       input logic [31:0] rd0, input logic [31:0] rd1);
        sb_t   e;
        bit    have;
        string who;
        who  = sel3 ? "lat3" : "lat1";
        have = sel3 ? (q3.size() > 0) : (q1.size() > 0);
        if (rv0 || rv1) begin
            tests++;
            if (rv0 && rv1) begin
                errors++;
                $display("FAIL %s rvalid_both: got r0_rvalid=1 r1_rvalid=1 expected at most one", who);
            end else if (!have) begin
                errors++;
                $display("FAIL %s rvalid_unexpected: got rvalid r0=%0b r1=%0b expected none (cycle %0d)",
                         who, rv0, rv1, cyc);
            end else begin
                e = sel3 ? q3.pop_front() : q1.pop_front();
                if (rv1 !== e.owner || (rv1 ? rd1 : rd0) !== e.data ||
                    rd0 !== rd1 || cyc != e.due) begin
                    errors++;
                    $display("FAIL %s rdata: got owner=%0b data=%h cycle=%0d expected owner=%0b data=%h cycle=%0d",
                             who, rv1, (rv1 ? rd1 : rd0), cyc, e.owner, e.data, e.due);
                end
            end
        end else if (have) begin
            e = sel3 ? q3[0] : q1[0];
            if (e.due <= cyc) begin
                tests++;
                errors++;
                $display("FAIL %s rvalid_missing: got no rvalid expected owner=%0b data=%h at cycle %0d",
                         who, e.owner, e.data, e.due);
                if (sel3) void'(q3.pop_front());
                else      void'(q1.pop_front());
            end
        end
    endtask

    // Check rvalid mid-cycle, then advance one clock.
    task automatic tick();
        @(negedge clk);
        mon(1'b0, a_r0_rvalid, a_r1_rvalid, a_r0_rdata, a_r1_rdata);
        mon(1'b1, b_r0_rvalid, b_r1_rvalid, b_r0_rdata, b_r1_rdata);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push_read(input logic owner, input logic [31:0] addr);
        sb_t e;
        e.owner = owner;
        e.data  = pat(addr);
        e.due   = cyc + 1;
        q1.push_back(e);
        e.due   = cyc + 3;
        q3.push_back(e);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [31:0] ea, ewd;
        logic        ew;
        r0_req = v.r0_req; r0_we = v.r0_we; r0_addr = v.r0_addr; r0_wdata = ~v.r0_addr;
        r1_req = v.r1_req; r1_we = v.r1_we; r1_lock = v.r1_lock;
        r1_addr = v.r1_addr; r1_wdata = ~v.r1_addr;
        #1;
        ea  = v.g0 ? v.r0_addr : (v.g1 ? v.r1_addr : 32'h0);
        ewd = v.g0 ? ~v.r0_addr : (v.g1 ? ~v.r1_addr : 32'h0);
        ew  = v.g0 ? v.r0_we : (v.g1 ? v.r1_we : 1'b0);
        chk($sformatf("row%0d r0_gnt", idx),    32'(a_r0_gnt),   32'(v.g0));
        chk($sformatf("row%0d r1_gnt", idx),    32'(a_r1_gnt),   32'(v.g1));
        chk($sformatf("row%0d r0_stall", idx),  32'(a_r0_stall), 32'(v.r0_req & ~v.g0));
        chk($sformatf("row%0d mem_en", idx),    32'(a_mem_en),   32'(v.g0 | v.g1));
        chk($sformatf("row%0d mem_we", idx),    32'(a_mem_we),   32'(ew));
        chk($sformatf("row%0d mem_addr", idx),  a_mem_addr,      ea);
        chk($sformatf("row%0d mem_wdata", idx), a_mem_wdata,     ewd);
        chk($sformatf("row%0d lat3 gnt", idx),  32'({b_r0_gnt, b_r1_gnt}), 32'({v.g0, v.g1}));
        if (v.g0 && !v.r0_we) push_read(1'b0, v.r0_addr);
        if (v.g1 && !v.r1_we) push_read(1'b1, v.r1_addr);
        $display("[TB] row %0d cyc %0d: req=%0b%0b lock=%0b gnt r0=%0b r1=%0b addr=%h",
                 idx, cyc, v.r0_req, v.r1_req, v.r1_lock, a_r0_gnt, a_r1_gnt, a_mem_addr);
        tick();
    endtask

    task automatic idle(input int n);
        r0_req = 1'b0; r1_req = 1'b0; r1_lock = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vec_t v;
        tests = 0; errors = 0; cyc = 0;
        rst_n = 1'b0;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = 0; r1_wdata = 0;

        // Test 1: single r0 read. Test 2: round-robin alternation.
        add(1,0,32'h10, 0,0,0,32'h0,   1,0);
        add(0,0,32'h0,  0,0,0,32'h0,   0,0);
        add(0,0,32'h0,  1,0,0,32'h20,  0,1);
        add(1,0,32'h30, 1,0,0,32'h40,  1,0);
        add(1,0,32'h34, 1,0,0,32'h40,  0,1);
        add(1,0,32'h34, 1,1,0,32'h44,  1,0);   // r1 changes we/addr while waiting
        add(1,1,32'h38, 1,1,0,32'h44,  0,1);
        add(0,0,32'h0,  0,0,0,32'h0,   0,0);
        // Test 3: locked r1 writes, r0 waits from the third beat
        add(0,0,32'h0,  1,1,1,32'h100, 0,1);
        add(0,0,32'h0,  1,1,1,32'h104, 0,1);
        for (int i = 0; i < 6; i++) add(1,0,32'h50, 1,1,1,32'h108 + 32'(4*i), 0,1);
        add(1,0,32'h50, 1,1,1,32'h120, 1,0);   // yield slot
        add(1,0,32'h54, 1,0,0,32'h120, 0,1);
        add(1,0,32'h54, 1,0,0,32'h124, 1,0);
        add(1,0,32'h58, 1,0,0,32'h124, 0,1);
        add(0,0,32'h0,  0,0,0,32'h0,   0,0);
        // Test 4: lock drops after 3 beats, burst count restarts
        add(0,0,32'h0,  1,1,1,32'h200, 0,1);
        add(1,0,32'h60, 1,1,1,32'h204, 0,1);
        add(1,0,32'h60, 1,1,1,32'h208, 0,1);
        add(1,0,32'h60, 1,1,0,32'h20C, 1,0);   // r0 served as lock drops
        add(0,0,32'h0,  1,1,1,32'h20C, 0,1);   // new burst, count 1
        for (int i = 0; i < 7; i++) add(1,0,32'h64, 1,1,1,32'h210 + 32'(4*i), 0,1);
        add(1,0,32'h64, 1,1,1,32'h240, 1,0);   // yield after exactly 8 beats
        // Saturated burst: r1 keeps going past MAX_BURST while r0 is idle
        add(0,0,32'h0,  1,1,1,32'h300, 0,1);
        for (int i = 0; i < 9; i++) add(0,0,32'h0, 1,1,1,32'h304 + 32'(4*i), 0,1);
        add(1,0,32'h70, 1,1,1,32'h330, 0,0);   // capped: give way to r0
        add(1,0,32'h70, 1,1,1,32'h330, 1,0);   // yield slot
        add(1,0,32'h74, 1,0,0,32'h330, 0,1);
        add(0,0,32'h0,  0,0,0,32'h0,   0,0);

        // Reset state
        repeat (2) tick();
        chk("reset r0_rvalid", 32'({a_r0_rvalid, b_r0_rvalid}), 32'h0);
        chk("reset r1_rvalid", 32'({a_r1_rvalid, b_r1_rvalid}), 32'h0);
        chk("reset mem_en",    32'({a_mem_en, b_mem_en}),       32'h0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            v = vecs[i];
            apply(v, i);
        end
        idle(4);

        // Test 5: back-to-back reads r0@4, r1@8, r0@C; lat3 returns 3 cycles later
        add(1,0,32'h4, 0,0,0,32'h0, 1,0);
        add(0,0,32'h0, 1,0,0,32'h8, 0,1);
        add(1,0,32'hC, 0,0,0,32'h0, 1,0);
        for (int i = vecs.size() - 3; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v, i);
        end
        idle(5);

        // Test 6: reset one cycle after a read grant drops the pending return
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h80; r0_wdata = 32'h0;
        #1;
        chk("rst6 pre gnt", 32'(a_r0_gnt), 32'h1);
        tick();
        r0_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst6 rvalid cleared", 32'({a_r0_rvalid, b_r0_rvalid}), 32'h0);
        tick();
        rst_n = 1'b1;
        idle(5);
        r0_req = 1'b1; r0_addr = 32'h84;
        r1_req = 1'b1; r1_addr = 32'h88; r1_we = 1'b0; r1_lock = 1'b0;
        #1;
        chk("rst6 tie r0_gnt", 32'({a_r0_gnt, b_r0_gnt}), 32'h3);
        chk("rst6 tie r1_gnt", 32'({a_r1_gnt, b_r1_gnt}), 32'h0);
        push_read(1'b0, 32'h84);
        tick();
        r0_req = 1'b0;
        #1;
        chk("rst6 r1 next", 32'(a_r1_gnt), 32'h1);
        push_read(1'b1, 32'h88);
        tick();
        idle(5);

        chk("scoreboard lat1 drained", 32'(q1.size()), 32'h0);
        chk("scoreboard lat3 drained", 32'(q3.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
